program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
Streaming boot loader that sits directly upstream of the instruction and data BRAMs of the rv32i single-core.
- Accepts a byte stream over a valid/ready handshake.
- Parses a 4-byte header, assembles little-endian 32-bit words and drives the BRAM write ports: instruction image first, then data image.
- Holds the core stalled until loading finishes, then releases pc_stall and hands data-BRAM write control to the core.

Parameters:
ADDR_WIDTH, 12, BRAM byte-address width
DATA_WIDTH, 32, word width
I_DEPTH_WORDS, 1024, instruction BRAM capacity in words
D_DEPTH_WORDS, 1024, data BRAM capacity in words

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
s_data  in  8  stream byte
s_valid  in  1  byte valid
s_ready  out  1  loader can accept a byte
start  in  1  one-cycle pulse; re-arms the loader from DONE or ERR
i_w_addr  out  ADDR_WIDTH  instruction BRAM write byte address
i_w_dat  out  DATA_WIDTH  instruction word
i_w_enb  out  1  instruction write strobe
i_w_byte_enb  out  4  instruction byte enables
d_w_addr  out  ADDR_WIDTH  data BRAM write byte address
d_w_dat  out  DATA_WIDTH  data word
d_w_enb  out  1  data write strobe
d_w_byte_enb  out  4  data byte enables
cpu_stall  out  1  drives pc stall
d_bram_init_done  out  1  data BRAM write mux select (1 = core owns the port)
load_done  out  1  image loaded
load_err  out  1  malformed image

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to HDR.
  - All addresses, data and counters clear to 0.
  - Write enables and byte enables are 0.
  - cpu_stall=1; d_bram_init_done=0; load_done=0; load_err=0.
- A byte transfers when s_valid&&s_ready. s_ready=1 in HDR, I_LOAD and D_LOAD; s_ready=0 in DONE and ERR.
- HDR: collect 4 bytes, little-endian.
  - Bytes 0-1 form icount[15:0]; bytes 2-3 form dcount[15:0].
  - After byte 3, with the checks applied in this order:
    - icount>I_DEPTH_WORDS or dcount>D_DEPTH_WORDS -> ERR.
    - icount!=0 -> I_LOAD.
    - dcount!=0 -> D_LOAD.
    - otherwise -> DONE.
- Word assembly:
  - Byte k of each word lands in bits [8k+7:8k].
  - On acceptance of byte 3 of a word, the write is registered.
  - Next cycle: the x_w_enb strobe pulses for exactly 1 cycle with x_w_byte_enb=4'b1111, x_w_addr=word_idx*4 and x_w_dat=the assembled word.
  - A byte accepted in that same cycle goes into the next word, so there is no stall. Throughput is 1 byte/cycle.
  - word_idx increments after each write and resets to 0 on the I_LOAD->D_LOAD transition.
- I_LOAD: after the write of word icount-1 is registered -> D_LOAD if dcount!=0, else DONE.
- D_LOAD: after the write of word dcount-1 is registered -> DONE.
- Transition timing: the state changes in the same cycle the final strobe asserts. DONE outputs take effect the following cycle, after the last write has completed.
- DONE: cpu_stall=0, d_bram_init_done=1, load_done=1. All write strobes stay 0.
- ERR: load_err=1, cpu_stall=1, d_bram_init_done=0.
- start pulse in DONE or ERR:
  - Return to HDR and clear the counters and flags.
  - cpu_stall returns to 1 and d_bram_init_done returns to 0 on the next cycle.
  - start is ignored in other states.
- Gaps: s_valid gaps of any length are legal. The partial word and the counters are held.
- Reset mid-load: immediate abort to HDR. No strobe is emitted. Partially written BRAM contents are not cleared.
- Addresses wrap modulo 2^ADDR_WIDTH. The header depth check prevents overflow at the default sizes.

Optional Feature:
LOADER_CHECKSUM_EN
- Defined:
  - A trailer byte follows the last payload byte; s_ready stays 1 for it in a CHK state.
  - The expected value is the XOR of all header and payload bytes.
  - Mismatch -> ERR; match -> DONE.
  - The zero-word image (icount=dcount=0) still carries a trailer.
- Undefined: no CHK state and no trailer; the image ends after the last payload byte.

Decomposition:
- Add to rv32i_params.vh: LOADER_HDR_BYTES (4), BYTES_PER_WORD (4), and the state encodings HDR, I_LOAD, D_LOAD, CHK, DONE, ERR.
- One sub-module, byte_word_assembler:
  - Contains the byte-lane shift register and the 2-bit byte counter.
  - Outputs word_valid for 1 cycle together with the 32-bit word.
- program_loader keeps the FSM, the counters and the port drivers.

Test Plan:
- Stream 06 00 03 00, then 6 instruction words and 3 data words, continuous valid:
  - 6 i_w_enb pulses at 0x0..0x14, then 3 d_w_enb pulses at 0x0,0x4,0x8, each with byte_enb=1111.
  - cpu_stall falls 1 cycle after the last d_w_enb; load_done=1.
  - Word bytes 13 05 50 00 write 0x00500513.
- Same image with random 0-5 cycle s_valid gaps -> identical write sequence and data; no extra strobes.
- Header 00 00 00 00 -> DONE, no strobes, cpu_stall=0, d_bram_init_done=1.
- Header 01 04 00 00 (icount=1025) -> ERR, load_err=1, cpu_stall=1, s_ready=0. Then pulse start -> HDR with s_ready=1.
- rst low after 2 bytes of the 3rd instruction word -> outputs at reset values. Reload a 1-word image -> a single write at 0x0.
- LOADER_CHECKSUM_EN, image 01 00 00 00 13 05 50 00:
  - Correct trailer 0x47 -> DONE.
  - Trailer 0x46 -> ERR.

Source files
------------

// File: rtl/program_loader_pkg.sv
// program_loader_pkg: shared constants, FSM state encoding and address helper for the boot loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Optional feature macro used by the loader: LOADER_CHECKSUM_EN (adds the CHK trailer state).
package program_loader_pkg;

  localparam int LOADER_HDR_BYTES = 4;
  localparam int BYTES_PER_WORD   = 4;

  typedef enum logic [2:0] {
    HDR    = 3'd0,
    I_LOAD = 3'd1,
    D_LOAD = 3'd2,
    CHK    = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } state_t;

  // Word index to BRAM byte address; callers truncate to their address width,
  // which gives the modulo-2^ADDR_WIDTH wrap.
  function automatic logic [31:0] word_byte_addr(input logic [15:0] idx);
    return {14'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/program_loader_byte_word_assembler.sv
// program_loader_byte_word_assembler: packs accepted bytes little-endian into words.
// Latency: word_vld/word_dat register 1 cycle after the 4th byte is accepted; word_next/word_last are same-cycle.
// Backpressure: none; byte_vld must only be raised for bytes the parent actually accepted.
//
// Ports:
//   clk, rst        clock, async active-low reset
//   clr             synchronous clear of the partial word and byte counter
//   byte_dat/vld    accepted stream byte
//   word_vld        1-cycle pulse with word_dat holding the completed word
//   word_next       the word as it would look including the current byte
//   word_last       current byte completes a word
module program_loader_byte_word_assembler
  import program_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic [7:0]            byte_dat,
  input  logic                  byte_vld,
  output logic                  word_vld,
  output logic [DATA_WIDTH-1:0] word_dat,
  output logic [DATA_WIDTH-1:0] word_next,
  output logic                  word_last
);

  logic [DATA_WIDTH-1:0] shreg;
  logic [1:0]            byte_cnt;

  // New bytes enter at the top and move down, so after four bytes byte k sits in [8k+7:8k].
  assign word_next = {byte_dat, shreg[DATA_WIDTH-1:8]};
  assign word_last = byte_vld && (byte_cnt == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg    <= '0;
      byte_cnt <= '0;
      word_vld <= 1'b0;
      word_dat <= '0;
    end else begin
      word_vld <= 1'b0;
      if (clr) begin
        shreg    <= '0;
        byte_cnt <= '0;
      end else if (byte_vld) begin
        shreg <= word_next;
        if (word_last) begin
          byte_cnt <= '0;
          word_vld <= 1'b1;
          word_dat <= word_next;
        end else begin
          byte_cnt <= byte_cnt + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/program_loader.sv
// program_loader: streaming boot loader writing instruction then data BRAM images, then releasing the core.
// Latency: a BRAM write strobes 1 cycle after the last byte of its word; 1 byte/cycle sustained.
// Backpressure: s_ready=1 while loading (HDR/I_LOAD/D_LOAD[/CHK]), 0 in DONE/ERR until a start pulse.
//
// Optional feature: define LOADER_CHECKSUM_EN to require an XOR trailer byte after the payload.
//
// Ports:
//   clk, rst                 clock, async active-low reset
//   s_data/s_valid/s_ready   byte stream in
//   start                    re-arm pulse from DONE or ERR
//   i_w_*                    instruction BRAM write port (byte address, word, strobe, byte enables)
//   d_w_*                    data BRAM write port
//   cpu_stall                holds the core PC while loading
//   d_bram_init_done         data BRAM write mux select, 1 = core owns the port
//   load_done, load_err      image loaded / malformed image
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_WIDTH    = 12,
  parameter int DATA_WIDTH    = 32,
  parameter int I_DEPTH_WORDS = 1024,
  parameter int D_DEPTH_WORDS = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] i_w_addr,
  output logic [DATA_WIDTH-1:0] i_w_dat,
  output logic                  i_w_enb,
  output logic [3:0]            i_w_byte_enb,
  output logic [ADDR_WIDTH-1:0] d_w_addr,
  output logic [DATA_WIDTH-1:0] d_w_dat,
  output logic                  d_w_enb,
  output logic [3:0]            d_w_byte_enb,
  output logic                  cpu_stall,
  output logic                  d_bram_init_done,
  output logic                  load_done,
  output logic                  load_err
);

`ifdef LOADER_CHECKSUM_EN
  localparam state_t PAYLOAD_END = CHK;
`else
  localparam state_t PAYLOAD_END = DONE;
`endif

  state_t                state;
  logic [15:0]           icount;
  logic [15:0]           dcount;
  logic [15:0]           word_idx;
  logic [1:0]            hdr_cnt;
  logic                  wr_to_i;
  logic                  wr_to_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            csum;
`endif

  logic                  accept;
  logic                  load_phase;
  logic                  asm_clr;
  logic                  word_vld;
  logic                  word_last;
  logic [DATA_WIDTH-1:0] word_dat;
  logic [DATA_WIDTH-1:0] word_next;
  logic [15:0]           hdr_icount;
  logic [15:0]           hdr_dcount;
  logic [ADDR_WIDTH-1:0] wr_addr;

  assign s_ready    = (state != DONE) && (state != ERR);
  assign accept     = s_valid && s_ready;
  // The trailer byte is consumed by the FSM only; it must not enter the word assembler.
  assign load_phase = (state == HDR) || (state == I_LOAD) || (state == D_LOAD);
  assign asm_clr    = start && ((state == DONE) || (state == ERR));

  program_loader_byte_word_assembler #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_asm (
    .clk       (clk),
    .rst       (rst),
    .clr       (asm_clr),
    .byte_dat  (s_data),
    .byte_vld  (accept && load_phase),
    .word_vld  (word_vld),
    .word_dat  (word_dat),
    .word_next (word_next),
    .word_last (word_last)
  );

  // Header fields are taken from the word as it completes, so the state decision lands on byte 3.
  assign hdr_icount = word_next[15:0];
  assign hdr_dcount = word_next[31:16];
  assign wr_addr    = ADDR_WIDTH'(word_byte_addr(word_idx));

  // The assembler's word pulse doubles as the strobe; wr_to_* steer it to one BRAM.
  // The header word also pulses word_vld, but neither steer flag is set for it.
  assign i_w_enb      = word_vld && wr_to_i;
  assign d_w_enb      = word_vld && wr_to_d;
  assign i_w_byte_enb = {4{i_w_enb}};
  assign d_w_byte_enb = {4{d_w_enb}};
  assign i_w_dat      = word_dat;
  assign d_w_dat      = word_dat;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= HDR;
      icount           <= '0;
      dcount           <= '0;
      word_idx         <= '0;
      hdr_cnt          <= '0;
      wr_to_i          <= 1'b0;
      wr_to_d          <= 1'b0;
      i_w_addr         <= '0;
      d_w_addr         <= '0;
      cpu_stall        <= 1'b1;
      d_bram_init_done <= 1'b0;
      load_done        <= 1'b0;
      load_err         <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum             <= '0;
`endif
    end else begin
      wr_to_i <= 1'b0;
      wr_to_d <= 1'b0;

      // Status flags follow the state one cycle later, so the final BRAM write
      // completes before the core is released or re-stalled.
      cpu_stall        <= (state != DONE);
      d_bram_init_done <= (state == DONE);
      load_done        <= (state == DONE);
      load_err         <= (state == ERR);

`ifdef LOADER_CHECKSUM_EN
      if (accept && load_phase) begin
        csum <= csum ^ s_data;
      end
`endif

      case (state)
        HDR: begin
          if (accept) begin
            if (hdr_cnt == 2'(LOADER_HDR_BYTES - 1)) begin
              hdr_cnt <= '0;
              icount  <= hdr_icount;
              dcount  <= hdr_dcount;
              if ((32'(hdr_icount) > I_DEPTH_WORDS) || (32'(hdr_dcount) > D_DEPTH_WORDS)) begin
                state <= ERR;
              end else if (hdr_icount != '0) begin
                state <= I_LOAD;
              end else if (hdr_dcount != '0) begin
                state <= D_LOAD;
              end else begin
                state <= PAYLOAD_END;
              end
            end else begin
              hdr_cnt <= hdr_cnt + 2'd1;
            end
          end
        end

        I_LOAD: begin
          if (word_last) begin
            wr_to_i  <= 1'b1;
            i_w_addr <= wr_addr;
            if (word_idx == icount - 16'd1) begin
              word_idx <= '0;
              state    <= (dcount != '0) ? D_LOAD : PAYLOAD_END;
            end else begin
              word_idx <= word_idx + 16'd1;
            end
          end
        end

        D_LOAD: begin
          if (word_last) begin
            wr_to_d  <= 1'b1;
            d_w_addr <= wr_addr;
            if (word_idx == dcount - 16'd1) begin
              word_idx <= '0;
              state    <= PAYLOAD_END;
            end else begin
              word_idx <= word_idx + 16'd1;
            end
          end
        end

`ifdef LOADER_CHECKSUM_EN
        CHK: begin
          if (accept) begin
            state <= (s_data == csum) ? DONE : ERR;
          end
        end
`endif

        DONE, ERR: begin
          if (start) begin
            state    <= HDR;
            icount   <= '0;
            dcount   <= '0;
            word_idx <= '0;
            hdr_cnt  <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
          end
        end

        default: state <= ERR;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed-vector bench for program_loader with an image-level write model.
// Latency: n/a (testbench).
// Backpressure: source honours s_ready and waits a bounded number of cycles for it.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_valid = 1'b0;
  logic        start = 1'b0;
  logic        s_ready;
  logic [11:0] i_w_addr, d_w_addr;
  logic [31:0] i_w_dat, d_w_dat;
  logic        i_w_enb, d_w_enb;
  logic [3:0]  i_w_byte_enb, d_w_byte_enb;
  logic        cpu_stall, d_bram_init_done, load_done, load_err;

  program_loader dut (
    .clk              (clk),
    .rst              (rst),
    .s_data           (s_data),
    .s_valid          (s_valid),
    .s_ready          (s_ready),
    .start            (start),
    .i_w_addr         (i_w_addr),
    .i_w_dat          (i_w_dat),
    .i_w_enb          (i_w_enb),
    .i_w_byte_enb     (i_w_byte_enb),
    .d_w_addr         (d_w_addr),
    .d_w_dat          (d_w_dat),
    .d_w_enb          (d_w_enb),
    .d_w_byte_enb     (d_w_byte_enb),
    .cpu_stall        (cpu_stall),
    .d_bram_init_done (d_bram_init_done),
    .load_done        (load_done),
    .load_err         (load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_d;
    int          addr;
    logic [31:0] dat;
  } wr_t;

  int          n_cmp = 0;
  int          n_fail = 0;
  wr_t         exp_q[$];
  logic [7:0]  img[$];
  bit          mon_en = 1'b0;
  wr_t         mon_e;
  logic [7:0]  xsum;

  logic [31:0] i_words [6] = '{32'h00500513, 32'h00A00593, 32'h00B50633,
                                32'h40C586B3, 32'hFFF00713, 32'h0000006F};
  logic [31:0] d_words [3] = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
    end
  endtask

  // ---------------- image model ----------------
  function automatic logic [31:0] word_at(input int o);
    return {img[o+3], img[o+2], img[o+1], img[o]};
  endfunction

  function automatic logic [7:0] img_xor();
    logic [7:0] x;
    x = 8'h00;
    foreach (img[i]) x ^= img[i];
    return x;
  endfunction

  task automatic push_word(input logic [31:0] w);
    img.push_back(w[7:0]);
    img.push_back(w[15:8]);
    img.push_back(w[23:16]);
    img.push_back(w[31:24]);
  endtask

  // Trailer byte exists only when the checksum feature is built in.
  task automatic finish_image();
`ifdef LOADER_CHECKSUM_EN
    img.push_back(img_xor());
`endif
  endtask

  // Expected BRAM writes: icount instruction words then dcount data words, byte addresses 4*index.
  task automatic load_expect();
    int  ic, dc, base;
    wr_t e;
    ic = int'({img[1], img[0]});
    dc = int'({img[3], img[2]});
    if (ic > 1024 || dc > 1024) return;
    for (int w = 0; w < ic; w++) begin
      e.is_d = 1'b0; e.addr = (w * 4) % 4096; e.dat = word_at(4 + 4 * w);
      exp_q.push_back(e);
    end
    base = 4 + 4 * ic;
    for (int w = 0; w < dc; w++) begin
      e.is_d = 1'b1; e.addr = (w * 4) % 4096; e.dat = word_at(base + 4 * w);
      exp_q.push_back(e);
    end
  endtask

  // ---------------- stimulus ----------------
  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    s_data  = b;
    s_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (s_ready) begin
        ok = 1'b1;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL s_ready_timeout: got s_ready=0 for 50 cycles, required 1");
    end
  endtask

  task automatic stream(input int max_gap, input int nbytes);
    for (int i = 0; i < nbytes; i++) begin
      if (max_gap > 0) begin
        repeat ($urandom_range(max_gap, 0)) begin
          @(posedge clk); #1;
        end
      end
      send_byte(img[i]);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("restart_s_ready", 32'(s_ready), 32'd1);
    @(negedge clk);
    chk("restart_cpu_stall", 32'(cpu_stall), 32'd1);
    chk("restart_init_done", 32'(d_bram_init_done), 32'd0);
    chk("restart_load_done", 32'(load_done), 32'd0);
    chk("restart_load_err", 32'(load_err), 32'd0);
  endtask

  task automatic expect_done(input string tag);
    repeat (2) @(negedge clk);
    chk({tag, "_cpu_stall"}, 32'(cpu_stall), 32'd0);
    chk({tag, "_init_done"}, 32'(d_bram_init_done), 32'd1);
    chk({tag, "_load_done"}, 32'(load_done), 32'd1);
    chk({tag, "_load_err"}, 32'(load_err), 32'd0);
    chk({tag, "_s_ready"}, 32'(s_ready), 32'd0);
    chk({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_s_ready"}, 32'(s_ready), 32'd1);
    chk({tag, "_cpu_stall"}, 32'(cpu_stall), 32'd1);
    chk({tag, "_init_done"}, 32'(d_bram_init_done), 32'd0);
    chk({tag, "_load_done"}, 32'(load_done), 32'd0);
    chk({tag, "_load_err"}, 32'(load_err), 32'd0);
    chk({tag, "_strobes"}, {28'd0, i_w_enb, d_w_enb, |i_w_byte_enb, |d_w_byte_enb}, 32'd0);
    chk({tag, "_addrs"}, {8'd0, i_w_addr, d_w_addr}, 32'd0);
    chk({tag, "_i_dat"}, i_w_dat, 32'd0);
  endtask

  // ---------------- write compare process ----------------
  always @(negedge clk) begin
    if (mon_en && rst && (i_w_enb || d_w_enb)) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL extra_strobe: got i_w_enb=%0b d_w_enb=%0b, required no strobe", i_w_enb, d_w_enb);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_both_ports", 32'(i_w_enb && d_w_enb), 32'd0);
        chk("wr_port_is_d", 32'(d_w_enb), 32'(mon_e.is_d));
        if (mon_e.is_d) begin
          chk("d_w_addr", 32'(d_w_addr), 32'(mon_e.addr));
          chk("d_w_dat", d_w_dat, mon_e.dat);
          chk("d_w_byte_enb", 32'(d_w_byte_enb), 32'hF);
        end else begin
          chk("i_w_addr", 32'(i_w_addr), 32'(mon_e.addr));
          chk("i_w_dat", i_w_dat, mon_e.dat);
          chk("i_w_byte_enb", 32'(i_w_byte_enb), 32'hF);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b1;
    mon_en = 1'b1;

    // 6 instruction words + 3 data words, continuous valid.
    img.delete();
    img.push_back(8'h06); img.push_back(8'h00); img.push_back(8'h03); img.push_back(8'h00);
    foreach (i_words[w]) push_word(i_words[w]);
    foreach (d_words[w]) push_word(d_words[w]);
    finish_image();
    load_expect();
    chk("model_size", 32'(exp_q.size()), 32'd9);
    chk("model_w0_dat", exp_q[0].dat, 32'h00500513);
    chk("model_i5_addr", 32'(exp_q[5].addr), 32'h14);
    chk("model_d0_is_d", 32'(exp_q[6].is_d), 32'd1);
    chk("model_d2_addr", 32'(exp_q[8].addr), 32'h8);
    stream(0, img.size());
`ifdef LOADER_CHECKSUM_EN
    expect_done("img1");
`else
    @(negedge clk);
    chk("img1_last_d_strobe", 32'(d_w_enb), 32'd1);
    chk("img1_stall_during_last", 32'(cpu_stall), 32'd1);
    chk("img1_done_during_last", 32'(load_done), 32'd0);
    @(negedge clk);
    chk("img1_cpu_stall", 32'(cpu_stall), 32'd0);
    chk("img1_init_done", 32'(d_bram_init_done), 32'd1);
    chk("img1_load_done", 32'(load_done), 32'd1);
    chk("img1_s_ready", 32'(s_ready), 32'd0);
    chk("img1_writes_left", 32'(exp_q.size()), 32'd0);
`endif

    // Same image with random s_valid gaps.
    pulse_start();
    load_expect();
    stream(5, img.size());
    expect_done("gaps");

    // Zero-word image.
    pulse_start();
    img.delete();
    repeat (4) img.push_back(8'h00);
    finish_image();
    load_expect();
    stream(0, img.size());
    expect_done("zero");

    // icount = 1025 exceeds the instruction BRAM.
    pulse_start();
    img.delete();
    img.push_back(8'h01); img.push_back(8'h04); img.push_back(8'h00); img.push_back(8'h00);
    load_expect();
    chk("model_err_no_writes", 32'(exp_q.size()), 32'd0);
    stream(0, img.size());
    repeat (2) @(negedge clk);
    chk("err_load_err", 32'(load_err), 32'd1);
    chk("err_cpu_stall", 32'(cpu_stall), 32'd1);
    chk("err_s_ready", 32'(s_ready), 32'd0);
    chk("err_init_done", 32'(d_bram_init_done), 32'd0);
    chk("err_load_done", 32'(load_done), 32'd0);
    pulse_start();

    // Reset after 2 bytes of the 3rd instruction word.
    img.delete();
    img.push_back(8'h04); img.push_back(8'h00); img.push_back(8'h00); img.push_back(8'h00);
    for (int w = 0; w < 4; w++) push_word(i_words[w]);
    load_expect();
    stream(0, 14);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    chk("midrst_writes_done", 32'(4 - exp_q.size()), 32'd2);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    img.delete();
    img.push_back(8'h01); img.push_back(8'h00); img.push_back(8'h00); img.push_back(8'h00);
    push_word(32'hCAFEF00D);
    finish_image();
    load_expect();
    stream(0, img.size());
    expect_done("reload");

`ifdef LOADER_CHECKSUM_EN
    // Trailer checks: XOR of 01 00 00 00 13 05 50 00 is 0x47.
    pulse_start();
    img.delete();
    img.push_back(8'h01); img.push_back(8'h00); img.push_back(8'h00); img.push_back(8'h00);
    img.push_back(8'h13); img.push_back(8'h05); img.push_back(8'h50); img.push_back(8'h00);
    load_expect();
    xsum = img_xor();
    chk("model_trailer", 32'(xsum), 32'h47);
    img.push_back(8'h47);
    stream(0, img.size());
    expect_done("csum_ok");

    pulse_start();
    img[8] = 8'h46;
    load_expect();
    stream(0, img.size());
    repeat (2) @(negedge clk);
    chk("csum_bad_load_err", 32'(load_err), 32'd1);
    chk("csum_bad_load_done", 32'(load_done), 32'd0);
    chk("csum_bad_cpu_stall", 32'(cpu_stall), 32'd1);
    chk("csum_bad_writes_left", 32'(exp_q.size()), 32'd0);
`endif

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
